issue_select_arbiter: RTL

//  Per-cycle select logic for the 16-entry centralized issue queue.
//  - Each issue port picks the oldest ready entry bound to that port.
//  - Grants are registered and drive the queue's arbit_addr/arbit_grant inputs.
//  - Owns the busy countdown for the non-pipelined divide port.
//  - Masks entries granted last cycle so nothing issues twice.

---
 rtl/issue_pkg.sv | 23 ++
 rtl/issue_oldest_pick.sv | 48 ++++
 rtl/issue_select_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared sizing, port encoding and modular age compare for the issue-queue select logic.
package issue_pkg;

  localparam int unsigned CIQ_DEPTH = 16;
  localparam int unsigned ISSUE_NUM = 4;
  localparam int unsigned AGE       = 5;
  localparam int unsigned ADDR_W    = $clog2(CIQ_DEPTH);
  localparam int unsigned PORT_W    = $clog2(ISSUE_NUM);
  localparam int unsigned DIV_PORT  = 2;
  localparam int unsigned DIV_LAT   = 8;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned PERF_W    = 32;

  typedef enum logic [PORT_W-1:0] {ALU0, ALU1, MDU, LSU} port_e;

  // a is older than b when (b - a) mod 2^AGE lies strictly inside the lower half-range.
  function automatic logic age_older(input logic [AGE-1:0] a, input logic [AGE-1:0] b);
    logic [AGE-1:0] diff;
    diff = b - a;
    return (diff != '0) && !diff[AGE-1];
  endfunction

endpackage

// File: rtl/issue_oldest_pick.sv
// Combinational tournament tree: finds the oldest candidate, ties resolve to the lower index.
module issue_oldest_pick
  import issue_pkg::*;
(
  input  logic [CIQ_DEPTH-1:0]          i_cand,
  input  logic [CIQ_DEPTH-1:0][AGE-1:0] i_age,
  output logic                          o_found_c,
  output logic [ADDR_W-1:0]             o_idx_c
);

  localparam int unsigned LVLS = ADDR_W;

  logic              w_v   [0:LVLS][0:CIQ_DEPTH-1];
  logic [ADDR_W-1:0] w_idx [0:LVLS][0:CIQ_DEPTH-1];
  logic [AGE-1:0]    w_age [0:LVLS][0:CIQ_DEPTH-1];

  always_comb begin
    for (int l = 0; l <= int'(LVLS); l++) begin
      for (int n = 0; n < int'(CIQ_DEPTH); n++) begin
        w_v[l][n]   = 1'b0;
        w_idx[l][n] = '0;
        w_age[l][n] = '0;
      end
    end
    for (int n = 0; n < int'(CIQ_DEPTH); n++) begin
      w_v[0][n]   = i_cand[n];
      w_idx[0][n] = ADDR_W'(n);
      w_age[0][n] = i_age[n];
    end
    // Left node holds the lower indices, so it wins unless the right is strictly older.
    for (int l = 0; l < int'(LVLS); l++) begin
      for (int k = 0; k < (int'(CIQ_DEPTH) >> (l + 1)); k++) begin
        if (w_v[l][2*k+1] && (!w_v[l][2*k] || age_older(w_age[l][2*k+1], w_age[l][2*k]))) begin
          w_idx[l+1][k] = w_idx[l][2*k+1];
          w_age[l+1][k] = w_age[l][2*k+1];
        end else begin
          w_idx[l+1][k] = w_idx[l][2*k];
          w_age[l+1][k] = w_age[l][2*k];
        end
        w_v[l+1][k] = w_v[l][2*k] | w_v[l][2*k+1];
      end
    end
  end

  assign o_found_c = w_v[LVLS][0];
  assign o_idx_c   = w_idx[LVLS][0];

endmodule

// File: rtl/issue_select_arbiter.sv
// Per-port oldest-ready select with registered grants, inflight masking and divider busy countdown.
// Optional ISSUE_ARB_PERF_EN adds wrapping grant / blocked-cycle counters.
module issue_select_arbiter
  import issue_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CIQ_DEPTH-1:0]             entry_req,
  input  logic [CIQ_DEPTH-1:0][AGE-1:0]    entry_age,
  input  logic [CIQ_DEPTH-1:0][PORT_W-1:0] entry_port,
  input  logic [CIQ_DEPTH-1:0]             entry_is_div,
  input  logic [ISSUE_NUM-1:0]             port_stall,
  output logic [ISSUE_NUM-1:0][ADDR_W-1:0] arbit_addr,
  output logic [ISSUE_NUM-1:0]             arbit_grant,
  output logic                             div_busy
`ifdef ISSUE_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]                perf_grants,
  output logic [PERF_W-1:0]                perf_blocked
`endif
);

  logic [ISSUE_NUM-1:0]             r_grant;
  logic [ISSUE_NUM-1:0][ADDR_W-1:0] r_addr;
  logic [CIQ_DEPTH-1:0]             r_inflight;
  logic [CNT_W-1:0]                 r_cnt;
  logic                             r_div_busy;

  logic [CIQ_DEPTH-1:0]             w_elig;
  logic [CIQ_DEPTH-1:0]             w_cand [ISSUE_NUM];
  logic [ISSUE_NUM-1:0]             w_found;
  logic [ADDR_W-1:0]                w_idx [ISSUE_NUM];
  logic [ISSUE_NUM-1:0]             w_blocked;
  logic [ISSUE_NUM-1:0]             w_gnt;
  logic [ISSUE_NUM-1:0][ADDR_W-1:0] w_addr_nxt;
  logic [CIQ_DEPTH-1:0]             w_inflight_nxt;
  logic                             w_div_load;
  logic [CNT_W-1:0]                 w_cnt_nxt;

  assign w_elig = entry_req & ~r_inflight;

  always_comb begin
    for (int p = 0; p < int'(ISSUE_NUM); p++) begin
      w_cand[p] = '0;
      for (int i = 0; i < int'(CIQ_DEPTH); i++) begin
        w_cand[p][i] = w_elig[i] && (entry_port[i] == PORT_W'(p));
      end
    end
  end

  for (genvar p = 0; p < int'(ISSUE_NUM); p++) begin : g_port
    issue_oldest_pick u_pick (
      .i_cand    (w_cand[p]),
      .i_age     (entry_age),
      .o_found_c (w_found[p]),
      .o_idx_c   (w_idx[p])
    );
    if (p == int'(DIV_PORT)) begin : g_div
      assign w_blocked[p] = port_stall[p] | r_div_busy;
    end else begin : g_plain
      assign w_blocked[p] = port_stall[p];
    end
    assign w_gnt[p]      = w_found[p] & ~w_blocked[p];
    assign w_addr_nxt[p] = w_gnt[p] ? w_idx[p] : r_addr[p];
  end

  // Entries granted this edge are masked next cycle; ports partition entries so no overlap.
  always_comb begin
    w_inflight_nxt = '0;
    for (int p = 0; p < int'(ISSUE_NUM); p++) begin
      if (w_gnt[p]) w_inflight_nxt[w_idx[p]] = 1'b1;
    end
  end

  assign w_div_load = w_gnt[DIV_PORT] & entry_is_div[w_idx[DIV_PORT]];

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_div_load) begin
      w_cnt_nxt = CNT_W'(DIV_LAT - 1);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_addr     <= '0;
      r_inflight <= '0;
      r_cnt      <= '0;
      r_div_busy <= 1'b0;
    end else begin
      r_grant    <= w_gnt;
      r_addr     <= w_addr_nxt;
      r_inflight <= w_inflight_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_busy <= (w_cnt_nxt != '0);
    end
  end

  assign arbit_grant = r_grant;
  assign arbit_addr  = r_addr;
  assign div_busy    = r_div_busy;

`ifdef ISSUE_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf_grants;
  logic [PERF_W-1:0] r_perf_blocked;
  logic [PERF_W-1:0] w_gnt_cnt;
  logic              w_any_blk;

  always_comb begin
    w_gnt_cnt = '0;
    for (int p = 0; p < int'(ISSUE_NUM); p++) begin
      w_gnt_cnt = w_gnt_cnt + PERF_W'(w_gnt[p]);
    end
  end

  assign w_any_blk = |(w_found & w_blocked);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_grants  <= '0;
      r_perf_blocked <= '0;
    end else begin
      r_perf_grants  <= r_perf_grants + w_gnt_cnt;
      r_perf_blocked <= r_perf_blocked + PERF_W'(w_any_blk);
    end
  end

  assign perf_grants  = r_perf_grants;
  assign perf_blocked = r_perf_blocked;
`endif

endmodule
